spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_flash_responder.sv | 188 ++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Opcodes and state encoding shared between the flash responder and the flash
// initiator, so both ends agree on the command set.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RESET = 8'hF0;

  localparam int ADDR_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } flash_state_t;

  // Byte address increment; wraps 0xFFFFFF -> 0x000000.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by a one-flop
// history register that yields single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_100mhz,
  input  logic nrst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-3 flash responder: serves READ (0x03) from a byte-wide memory port
// with auto-incrementing address and flags RESET (0xF0); all in clk_100mhz.
//
// state     | meaning
// ST_IDLE   | csn high, waiting for a csn falling edge
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in the 24-bit start address
// ST_DATA   | streaming memory bytes out on miso
// ST_IGNORE | unsupported/finished command, waiting for csn high
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_LAT     = 1
) (
  input  logic        clk_100mhz,
  input  logic        nrst,
  input  logic        sclk,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        rst_cmd,
  output logic        busy
);

  localparam int STG  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int LAT  = (MEM_LAT >= 2) ? 2 : 1;
  localparam int SU_W = $clog2(STG + 2) + 1;
  localparam logic [SU_W-1:0] SU_DONE  = SU_W'(STG + 1);
  localparam logic [LAT-1:0]  PEND_LSB = LAT'(1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(STG), .RST_VAL(1'b1)) u_sync_sclk (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .d          (sclk),
    .q          (sclk_lvl_unused),
    .rise       (sclk_rise),
    .fall       (sclk_fall)
  );

  spi_sync_edge #(.STAGES(STG), .RST_VAL(1'b1)) u_sync_csn (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .d          (csn),
    .q          (csn_s),
    .rise       (csn_rise),
    .fall       (csn_fall)
  );

  spi_sync_edge #(.STAGES(STG), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .d          (mosi),
    .q          (mosi_s),
    .rise       (mosi_rise_unused),
    .fall       (mosi_fall_unused)
  );

  flash_state_t      state;
  logic [4:0]        bit_cnt;
  logic [7:0]        cmd_sr;
  logic [7:0]        out_sr;
  logic [23:0]       addr;
  logic [LAT-1:0]    pend;
  logic [SU_W-1:0]   su_cnt;
  logic              armed;

  logic [7:0]  cmd_next;
  logic [23:0] addr_next;

  assign cmd_next  = {cmd_sr[6:0], mosi_s};
  assign addr_next = {addr[22:0], mosi_s};

  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      cmd_sr   <= '0;
      out_sr   <= '0;
      addr     <= '0;
      pend     <= '0;
      su_cnt   <= '0;
      armed    <= 1'b0;
      miso     <= 1'b1;
      miso_oe  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      rst_cmd  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mem_rd  <= 1'b0;
      rst_cmd <= 1'b0;
      pend    <= (pend << 1) | (mem_rd ? PEND_LSB : '0);

      // The csn synchronizer comes out of reset reading "high"; a csn already
      // low at release would look like a falling edge. Only arm once real
      // samples have filled the chain and csn has actually been seen high.
      if (su_cnt != SU_DONE) su_cnt <= su_cnt + SU_W'(1);
      else if (csn_s)        armed  <= 1'b1;

      if (csn_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        pend    <= '0;
        miso_oe <= 1'b0;
        miso    <= 1'b1;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (csn_fall && armed) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
              cmd_sr  <= '0;
              busy    <= 1'b1;
            end
          end

          ST_CMD: begin
            if (sclk_rise) begin
              cmd_sr <= cmd_next;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (cmd_next == OP_READ) begin
                  state <= ST_ADDR;
                  addr  <= '0;
                end else begin
                  state <= ST_IGNORE;
                  if (cmd_next == OP_RESET) rst_cmd <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ST_ADDR: begin
            if (sclk_rise) begin
              addr <= addr_next;
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                mem_rd   <= 1'b1;
                mem_addr <= addr_next;
                miso_oe  <= 1'b1;
                state    <= ST_DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ST_DATA: begin
            if (sclk_fall) begin
              miso   <= out_sr[7];
              out_sr <= {out_sr[6:0], 1'b0};
            end else if (sclk_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                addr     <= addr_inc(addr);
                mem_addr <= addr_inc(addr);
                mem_rd   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ST_IGNORE: ;

          default: state <= ST_IDLE;
        endcase

        // Fetch lands between the 8th rise and the next fall, so it never
        // collides with a shift.
        if (pend[LAT-1]) out_sr <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench: two responders (MEM_LAT 1 and 2) share one SPI initiator;
// each has its own memory model and output monitor.
module tb_spi_flash_responder;

  localparam int HP = 8;

  logic clk_100mhz = 1'b0;
  logic nrst = 1'b0;
  logic sclk = 1'b1;
  logic csn = 1'b1;
  logic mosi = 1'b0;

  logic miso1, oe1, rd1, rc1, busy1;
  logic miso2, oe2, rd2, rc2, busy2;
  logic [23:0] addr1, addr2;
  logic [7:0]  rdata1 = 8'h00;
  logic [7:0]  rdata2 = 8'h00;
  logic [7:0]  stage2 = 8'h00;

  always #5 clk_100mhz = ~clk_100mhz;

  spi_flash_responder #(.SYNC_STAGES(2), .MEM_LAT(1)) u_dut1 (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .sclk       (sclk),
    .csn        (csn),
    .mosi       (mosi),
    .miso       (miso1),
    .miso_oe    (oe1),
    .mem_rd     (rd1),
    .mem_addr   (addr1),
    .mem_rdata  (rdata1),
    .rst_cmd    (rc1),
    .busy       (busy1)
  );

  spi_flash_responder #(.SYNC_STAGES(2), .MEM_LAT(2)) u_dut2 (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .sclk       (sclk),
    .csn        (csn),
    .mosi       (mosi),
    .miso       (miso2),
    .miso_oe    (oe2),
    .mem_rd     (rd2),
    .mem_addr   (addr2),
    .mem_rdata  (rdata2),
    .rst_cmd    (rc2),
    .busy       (busy2)
  );

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hA5;
      24'h000011: return 8'h3C;
      24'h000012: return 8'hFF;
      24'hFFFFFF: return 8'h5A;
      24'h000000: return 8'hC3;
      24'h000001: return 8'h96;
      default:    return a[7:0] ^ 8'h6B;
    endcase
  endfunction

  always @(posedge clk_100mhz) begin
    if (rd1) rdata1 <= mem_val(addr1);
    if (rd2) stage2 <= mem_val(addr2);
    rdata2 <= stage2;
  end

  int oe_cnt1 = 0, oe_cnt2 = 0, rc_cnt1 = 0, rc_cnt2 = 0;
  int consec = 0, bad_idle = 0;
  logic prev_rd1 = 1'b0, prev_rd2 = 1'b0;
  logic [23:0] log1[$];
  logic [23:0] log2[$];

  always @(negedge clk_100mhz) begin
    if (oe1) oe_cnt1++;
    if (oe2) oe_cnt2++;
    if (rc1) rc_cnt1++;
    if (rc2) rc_cnt2++;
    if (rd1) log1.push_back(addr1);
    if (rd2) log2.push_back(addr2);
    if ((rd1 && prev_rd1) || (rd2 && prev_rd2)) consec++;
    if ((!oe1 && !miso1) || (!oe2 && !miso2)) bad_idle++;
    prev_rd1 = rd1;
    prev_rd2 = rd2;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic xfer_n(input logic [7:0] tx, input int n,
                        output logic [7:0] rx1, output logic [7:0] rx2);
    rx1 = 8'h00;
    rx2 = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0;
      mosi = tx[i];
      cyc(HP);
      rx1[i] = miso1;
      rx2[i] = miso2;
      sclk = 1'b1;
      cyc(HP);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx1, output logic [7:0] rx2);
    xfer_n(tx, 8, rx1, rx2);
  endtask

  task automatic cs_low();
    csn = 1'b0;
    cyc(HP);
  endtask

  task automatic cs_high();
    cyc(HP);
    csn = 1'b1;
    cyc(2 * HP);
  endtask

  function automatic logic [63:0] outs1();
    return {35'd0, miso1, oe1, rd1, addr1, rc1, busy1};
  endfunction

  function automatic logic [63:0] outs2();
    return {35'd0, miso2, oe2, rd2, addr2, rc2, busy2};
  endfunction

  localparam logic [63:0] RESET_OUTS = 64'h1000_0000;

  initial begin
    logic [7:0] r1, r2;
    int b1, b2, o1, o2, c1, c2;

    cyc(5);
    chk("reset_outs_d1", outs1(), RESET_OUTS);
    chk("reset_outs_d2", outs2(), RESET_OUTS);
    nrst = 1'b1;
    cyc(20);

    // READ 0x000010, three bytes
    b1 = log1.size(); b2 = log2.size();
    cs_low();
    xfer(8'h03, r1, r2);
    chk("cmd_phase_miso_idle", {r1, r2}, 16'hFFFF);
    xfer(8'h00, r1, r2);
    xfer(8'h00, r1, r2);
    xfer(8'h10, r1, r2);
    chk("addr_phase_miso_idle", {r1, r2}, 16'hFFFF);
    xfer(8'h00, r1, r2);
    chk("rd_byte0", {r1, r2}, 16'hA5A5);
    xfer(8'h00, r1, r2);
    chk("rd_byte1", {r1, r2}, 16'h3C3C);
    chk("busy_in_data", {busy1, busy2, oe1, oe2}, 4'b1111);
    xfer(8'h00, r1, r2);
    chk("rd_byte2", {r1, r2}, 16'hFFFF);
    cs_high();
    chk("rd_count_d1", log1.size() - b1, 4);
    chk("rd_count_d2", log2.size() - b2, 4);
    chk("rd_addrs_d1", {log1[b1], log1[b1+1], log1[b1+2], log1[b1+3]},
        {24'h10, 24'h11, 24'h12, 24'h13});
    chk("rd_addrs_d2", {log2[b2], log2[b2+3]}, {24'h10, 24'h13});
    chk("idle_after_read", {busy1, busy2, oe1, oe2, miso1, miso2}, 6'b000011);

    // RESET opcode
    b1 = log1.size(); b2 = log2.size();
    o1 = oe_cnt1; o2 = oe_cnt2; c1 = rc_cnt1; c2 = rc_cnt2;
    cs_low();
    xfer(8'hF0, r1, r2);
    cs_high();
    chk("rst_cmd_pulses", {rc_cnt1 - c1, rc_cnt2 - c2}, {32'd1, 32'd1});
    chk("rst_no_oe", {oe_cnt1 - o1, oe_cnt2 - o2}, 64'd0);
    chk("rst_no_rd", {log1.size() - b1, log2.size() - b2}, 64'd0);

    // Unsupported opcode, 32 more clocks
    b1 = log1.size(); b2 = log2.size();
    o1 = oe_cnt1; o2 = oe_cnt2; c1 = rc_cnt1;
    cs_low();
    xfer(8'h9F, r1, r2);
    for (int k = 0; k < 4; k++) xfer(8'h03, r1, r2);
    chk("ignore_busy", {busy1, busy2}, 2'b11);
    chk("ignore_miso", {r1, r2}, 16'hFFFF);
    cs_high();
    chk("ignore_idle", {busy1, busy2}, 2'b00);
    chk("ignore_no_oe", {oe_cnt1 - o1, oe_cnt2 - o2}, 64'd0);
    chk("ignore_no_rd", {log1.size() - b1, log2.size() - b2}, 64'd0);
    chk("ignore_no_rst", rc_cnt1 - c1, 0);

    // Address wrap
    b1 = log1.size(); b2 = log2.size();
    cs_low();
    xfer(8'h03, r1, r2);
    xfer(8'hFF, r1, r2);
    xfer(8'hFF, r1, r2);
    xfer(8'hFF, r1, r2);
    xfer(8'h00, r1, r2);
    chk("wrap_byte0", {r1, r2}, 16'h5A5A);
    xfer(8'h00, r1, r2);
    chk("wrap_byte1", {r1, r2}, 16'hC3C3);
    cs_high();
    chk("wrap_addrs_d1", {log1[b1], log1[b1+1]}, {24'hFFFFFF, 24'h000000});
    chk("wrap_addrs_d2", {log2[b2], log2[b2+1]}, {24'hFFFFFF, 24'h000000});

    // Aborted address, then fresh read at 0x000001
    b1 = log1.size(); b2 = log2.size();
    cs_low();
    xfer(8'h03, r1, r2);
    xfer(8'hFF, r1, r2);
    xfer_n(8'hF0, 4, r1, r2);
    cs_high();
    chk("abort_no_rd", {log1.size() - b1, log2.size() - b2}, 64'd0);
    chk("abort_idle", {busy1, busy2}, 2'b00);
    cs_low();
    xfer(8'h03, r1, r2);
    xfer(8'h00, r1, r2);
    xfer(8'h00, r1, r2);
    xfer(8'h01, r1, r2);
    xfer(8'h00, r1, r2);
    chk("after_abort_byte", {r1, r2}, 16'h9696);
    cs_high();
    chk("after_abort_addr", {log1[b1], log2[b2]}, {24'h000001, 24'h000001});

    // Reset in the middle of a data byte
    cs_low();
    xfer(8'h03, r1, r2);
    xfer(8'h00, r1, r2);
    xfer(8'h00, r1, r2);
    xfer(8'h10, r1, r2);
    xfer(8'h00, r1, r2);
    chk("pre_reset_byte", {r1, r2}, 16'hA5A5);
    xfer_n(8'h00, 4, r1, r2);
    nrst = 1'b0;
    #1;
    chk("midreset_outs_d1", outs1(), RESET_OUTS);
    chk("midreset_outs_d2", outs2(), RESET_OUTS);
    cyc(5);
    b1 = log1.size(); b2 = log2.size();
    nrst = 1'b1;
    cyc(20);
    chk("csn_low_at_release", {busy1, busy2}, 2'b00);
    xfer(8'h03, r1, r2);
    chk("no_start_without_fall", {busy1, busy2, oe1, oe2}, 4'b0000);
    chk("no_rd_without_fall", {log1.size() - b1, log2.size() - b2}, 64'd0);
    csn = 1'b1;
    cyc(2 * HP);
    cs_low();
    xfer(8'h03, r1, r2);
    xfer(8'h00, r1, r2);
    xfer(8'h00, r1, r2);
    xfer(8'h11, r1, r2);
    xfer(8'h00, r1, r2);
    chk("post_reset_byte0", {r1, r2}, 16'h3C3C);
    xfer(8'h00, r1, r2);
    chk("post_reset_byte1", {r1, r2}, 16'hFFFF);
    cs_high();
    chk("post_reset_addrs_d2", {log2[b2], log2[b2+1]}, {24'h11, 24'h12});

    chk("mem_rd_never_back_to_back", consec, 0);
    chk("miso_high_when_not_driven", bad_idle, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
